// File: rtl/safety_pkg.sv
// Shared types and constants for the safety-system indicator blocks.
package safety_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF,
        GAP
    } blink_state_t;

    // Fault code value meaning "nothing to report".
    localparam int NO_FAULT = 0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Loadable down-counter that saturates at zero and flags when it gets there.
module blink_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/fault_blink_encoder.sv
// Blinks a fault code on one LED: N pulses, a long pause, repeat until cleared.
// New codes posted mid-sequence wait in a one-deep pending slot for the pause.
module fault_blink_encoder
    import safety_pkg::*;
#(
    parameter int CODE_W     = 4,
    parameter int ON_CYCLES  = 12_500_000,
    parameter int OFF_CYCLES = 12_500_000,
    parameter int GAP_CYCLES = 50_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] code,
    input  logic              clear,
    output logic              led,
    output logic              busy,
    output logic [CODE_W-1:0] active_code
);

    localparam int MAX_CYCLES = max3(ON_CYCLES, OFF_CYCLES, GAP_CYCLES);
    localparam int TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [CODE_W-1:0]  NO_CODE  = CODE_W'(NO_FAULT);

    blink_state_t      state_q, state_d;
    logic [CODE_W-1:0] active_code_q, active_code_d;
    logic [CODE_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [CODE_W-1:0] pending_q, pending_d;
    logic              pending_valid_q, pending_valid_d;
    logic              led_q, led_d;

    logic               timer_load;
    logic [TIMER_W-1:0] timer_load_value;
    logic               timer_zero;

    blink_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .clock       (clock),
        .reset       (reset),
        .load_i      (timer_load),
        .load_value_i(timer_load_value),
        .zero_o      (timer_zero)
    );

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d          = state_q;
        active_code_d    = active_code_q;
        blink_cnt_d      = blink_cnt_q;
        pending_d        = pending_q;
        pending_valid_d  = pending_valid_q;
        timer_load       = 1'b0;
        timer_load_value = '0;

        if (clear) begin
            state_d          = IDLE;
            active_code_d    = NO_CODE;
            pending_valid_d  = 1'b0;
            timer_load       = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (code_valid && code != NO_CODE) begin
                        state_d          = ON;
                        active_code_d    = code;
                        blink_cnt_d      = code;
                        timer_load       = 1'b1;
                        timer_load_value = ON_LOAD;
                    end
                end
                ON: begin
                    if (timer_zero) begin
                        state_d          = OFF;
                        blink_cnt_d      = blink_cnt_q - 1'b1;
                        timer_load       = 1'b1;
                        timer_load_value = OFF_LOAD;
                    end
                end
                OFF: begin
                    if (timer_zero) begin
                        timer_load = 1'b1;
                        if (blink_cnt_q != '0) begin
                            state_d          = ON;
                            timer_load_value = ON_LOAD;
                        end else begin
                            state_d          = GAP;
                            timer_load_value = GAP_LOAD;
                        end
                    end
                end
                GAP: begin
                    if (timer_zero) begin
                        timer_load       = 1'b1;
                        timer_load_value = ON_LOAD;
                        state_d          = ON;
                        blink_cnt_d      = active_code_q;
                        if (pending_valid_q) begin
                            pending_valid_d = 1'b0;
                            active_code_d   = pending_q;
                            blink_cnt_d     = pending_q;
                            if (pending_q == NO_CODE) begin
                                state_d    = IDLE;
                                timer_load = 1'b0;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            // Later writes win; a strobe on the GAP-exit edge lands here after the adopt above.
            if (code_valid && state_q != IDLE) begin
                pending_d       = code;
                pending_valid_d = 1'b1;
            end
        end

        led_d = (state_d == ON);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            active_code_q   <= '0;
            blink_cnt_q     <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            led_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            active_code_q   <= active_code_d;
            blink_cnt_q     <= blink_cnt_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            led_q           <= led_d;
        end
    end

    assign led         = led_q;
    assign busy        = (state_q != IDLE);
    assign active_code = active_code_q;

endmodule

// File: tb/tb_fault_blink_encoder.sv
// Self-checking bench: phase-based reference model compared every cycle,
// plus directed scenarios with hand-computed blink counts and patterns.
module tb_fault_blink_encoder;

    localparam int CODE_W = 4;
    localparam int ON     = 3;
    localparam int OFF    = 2;
    localparam int GAP    = 5;

    logic              clock      = 1'b0;
    logic              reset      = 1'b1;
    logic              code_valid = 1'b0;
    logic [CODE_W-1:0] code       = '0;
    logic              clear      = 1'b0;
    logic              led;
    logic              busy;
    logic [CODE_W-1:0] active_code;

    int errors = 0;
    int checks = 0;

    fault_blink_encoder #(
        .CODE_W    (CODE_W),
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF),
        .GAP_CYCLES(GAP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .code_valid (code_valid),
        .code       (code),
        .clear      (clear),
        .led        (led),
        .busy       (busy),
        .active_code(active_code)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: the code being shown and the position within its
    // N*(ON+OFF)+GAP period; led is derived arithmetically from the position.
    int m_code       = 0;
    int m_phase      = 0;
    int m_pend       = 0;
    int m_pend_valid = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_code       = 0;
            m_phase      = 0;
            m_pend       = 0;
            m_pend_valid = 0;
        end else if (clear) begin
            m_code       = 0;
            m_phase      = 0;
            m_pend_valid = 0;
        end else if (m_code == 0) begin
            if (code_valid && code != 0) begin
                m_code  = int'(code);
                m_phase = 0;
            end
        end else begin
            if (m_phase == m_code * (ON + OFF) + GAP - 1) begin
                m_phase = 0;
                if (m_pend_valid != 0) begin
                    m_pend_valid = 0;
                    m_code       = m_pend;
                end
            end else begin
                m_phase++;
            end
            if (code_valid) begin
                m_pend       = int'(code);
                m_pend_valid = 1;
            end
        end
    end

    function automatic int exp_led();
        if (m_code == 0) return 0;
        if (m_phase >= m_code * (ON + OFF)) return 0;
        return ((m_phase % (ON + OFF)) < ON) ? 1 : 0;
    endfunction

    always @(negedge clock) begin
        check("model_led", int'(led), exp_led());
        check("model_busy", int'(busy), (m_code != 0) ? 1 : 0);
        check("model_active_code", int'(active_code), m_code);
    end

    task automatic strobe(input int c);
        code_valid = 1'b1;
        code       = CODE_W'(c);
        @(negedge clock);
        code_valid = 1'b0;
        code       = '0;
    endtask

    task automatic count_blinks(input int cycles, output int n);
        int prev;
        prev = 0;
        n    = 0;
        for (int i = 0; i < cycles; i++) begin
            if (led && prev == 0) n++;
            prev = int'(led);
            @(negedge clock);
        end
    endtask

    // what: 0 = led, 1 = busy, 2 = active_code
    task automatic wait_for(input string name, input int what, input int val, input int budget);
        int seen;
        int got;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            seen = (what == 0) ? int'(led) : (what == 1) ? int'(busy) : int'(active_code);
            if (seen == val) begin
                got = 1;
                break;
            end
            @(negedge clock);
        end
        check(name, got, 1);
    endtask

    initial begin
        logic [14:0] pattern;
        int          n;

        repeat (2) @(negedge clock);
        check("reset_led", int'(led), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_active", int'(active_code), 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("idle_after_reset", int'(busy), 0);

        // Code 2: exact 15-cycle pattern starting one cycle after the strobe.
        strobe(2);
        pattern = '0;
        for (int i = 0; i < 15; i++) begin
            pattern = {pattern[13:0], led};
            @(negedge clock);
        end
        check("code2_pattern", int'(pattern), int'(15'b111_00_111_00_00000));

        // Code 3 posted during the second ON of code 2 waits for the gap.
        repeat (5) @(negedge clock);
        strobe(3);
        check("code3_not_yet", int'(active_code), 2);
        wait_for("wait_code3", 2, 3, 30);
        count_blinks(20, n);
        check("code3_blinks", n, 3);

        // Asynchronous reset while lit, observed between clock edges.
        wait_for("wait_led_on", 0, 1, 20);
        #2 reset = 1'b1;
        #1;
        check("async_reset_led", int'(led), 0);
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_active", int'(active_code), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check("idle_after_async_reset", int'(busy), 0);

        // Code 0 posted during code 1 stops it at the gap; code 0 in idle is ignored.
        strobe(1);
        strobe(0);
        wait_for("wait_stop", 1, 0, 30);
        check("stop_led", int'(led), 0);
        check("stop_active", int'(active_code), 0);
        strobe(0);
        repeat (3) @(negedge clock);
        check("zero_in_idle", int'(busy), 0);

        // Max code: 15 blinks in an 80-cycle period, then clear beats a code strobe.
        strobe(15);
        count_blinks(80, n);
        check("code15_blinks", n, 15);
        check("code15_restart", int'(led), 1);
        repeat (10) @(negedge clock);
        clear      = 1'b1;
        code_valid = 1'b1;
        code       = 4'd5;
        @(negedge clock);
        clear      = 1'b0;
        code_valid = 1'b0;
        code       = '0;
        check("clear_busy", int'(busy), 0);
        count_blinks(100, n);
        check("clear_discards_code", n, 0);

        // Strobe exactly on the gap-exit edge of code 2: one more code-2 round first.
        strobe(2);
        repeat (14) @(negedge clock);
        strobe(4);
        count_blinks(15, n);
        check("gap_edge_code2_again", n, 2);
        check("gap_edge_code4_active", int'(active_code), 4);
        count_blinks(25, n);
        check("gap_edge_code4_blinks", n, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
